// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for one shared ALU; ALU_ARBITER_FIXED_PRIO_EN selects fixed priority
module alu_arbiter #(
    parameter int OP_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_valid_i,
    input  logic [31:0]     req0_a_i,
    input  logic [31:0]     req0_b_i,
    input  logic [OP_W-1:0] req0_op_i,
    output logic            req0_ready_o,
    input  logic            req1_valid_i,
    input  logic [31:0]     req1_a_i,
    input  logic [31:0]     req1_b_i,
    input  logic [OP_W-1:0] req1_op_i,
    output logic            req1_ready_o,
    output logic            rsp0_valid_o,
    output logic [31:0]     rsp0_result_o,
    output logic            rsp0_flag_o,
    input  logic            rsp0_ready_i,
    output logic            rsp1_valid_o,
    output logic [31:0]     rsp1_result_o,
    output logic            rsp1_flag_o,
    input  logic            rsp1_ready_i,
    output logic [31:0]     alu_a_o,
    output logic [31:0]     alu_b_o,
    output logic [OP_W-1:0] alu_op_o,
    input  logic [31:0]     alu_result_i,
    input  logic            alu_flag_i
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nx;
    logic last, g0, g1, open;
    assign open = state == IDLE && !rst_i;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    assign g0 = open && req0_valid_i;
`else
    assign g0 = open && req0_valid_i && (!req1_valid_i || last);
`endif
    assign g1 = open && req1_valid_i && !g0;
    assign req0_ready_o = g0;
    assign req1_ready_o = g1;
    assign alu_a_o  = g0 ? req0_a_i  : g1 ? req1_a_i  : '0;
    assign alu_b_o  = g0 ? req0_b_i  : g1 ? req1_b_i  : '0;
    assign alu_op_o = g0 ? req0_op_i : g1 ? req1_op_i : '0;
    // last doubles as the port whose response is outstanding while in RESP
    always_comb begin
        state_nx = state;
        if (state == IDLE && (g0 || g1))
            state_nx = RESP;
        else if (state == RESP && (last ? rsp1_ready_i : rsp0_ready_i))
            state_nx = IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            last          <= 1'b1;
            rsp0_valid_o  <= 1'b0;
            rsp0_result_o <= '0;
            rsp0_flag_o   <= 1'b0;
            rsp1_valid_o  <= 1'b0;
            rsp1_result_o <= '0;
            rsp1_flag_o   <= 1'b0;
        end else begin
            state <= state_nx;
            if (g0) begin
                rsp0_valid_o  <= 1'b1;
                rsp0_result_o <= alu_result_i;
                rsp0_flag_o   <= alu_flag_i;
                last          <= 1'b0;
            end
            if (g1) begin
                rsp1_valid_o  <= 1'b1;
                rsp1_result_o <= alu_result_i;
                rsp1_flag_o   <= alu_flag_i;
                last          <= 1'b1;
            end
            if (state == RESP && state_nx == IDLE) begin
                if (last)
                    rsp1_valid_o <= 1'b0;
                else
                    rsp0_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_XOR = 5'd4, ALU_LTS = 5'd8;
    logic clk = 0, rst = 1;
    logic [1:0] v = 0, rdy = 0;
    logic [31:0] a [2], b [2];
    logic [4:0] op [2];
    logic r0, r1, rv0, rv1, rf0, rf1, alu_flag;
    logic [31:0] rr0, rr1, alu_a, alu_b, alu_result;
    logic [4:0] alu_op;
    int checks = 0, errs = 0;
    bit m_busy = 0;
    int m_last = 1, last_g = -1;
    logic m_rv [2], m_rf [2];
    logic [31:0] m_rr [2];

    always #5 clk = ~clk;

    function automatic logic [32:0] alu(input logic [31:0] x, input logic [31:0] y, input logic [4:0] o);
        logic [31:0] res;
        case (o)
            ALU_ADD: res = x + y;
            ALU_SUB: res = x - y;
            ALU_XOR: res = x ^ y;
            ALU_LTS: res = {31'd0, $signed(x) < $signed(y)};
            default: return 33'd0;
        endcase
        return {o == ALU_LTS ? res[0] : res == 0, res};
    endfunction

    assign {alu_flag, alu_result} = alu(alu_a, alu_b, alu_op);

    alu_arbiter #(.OP_W(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v[0]), .req0_a_i(a[0]), .req0_b_i(b[0]), .req0_op_i(op[0]), .req0_ready_o(r0),
        .req1_valid_i(v[1]), .req1_a_i(a[1]), .req1_b_i(b[1]), .req1_op_i(op[1]), .req1_ready_o(r1),
        .rsp0_valid_o(rv0), .rsp0_result_o(rr0), .rsp0_flag_o(rf0), .rsp0_ready_i(rdy[0]),
        .rsp1_valid_o(rv1), .rsp1_result_o(rr1), .rsp1_flag_o(rf1), .rsp1_ready_i(rdy[1]),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result), .alu_flag_i(alu_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, check combinational outputs, then registered ones after the edge
    task automatic step(input logic [1:0] vv, input logic [1:0] rd, input logic rs);
        int g;
        logic [32:0] res;
        v = vv; rdy = rd; rst = rs;
        g = -1;
        if (!rs && !m_busy) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            if (vv == 2'b11) g = 0;
`else
            if (vv == 2'b11) g = 1 - m_last;
`endif
            else if (vv[0]) g = 0;
            else if (vv[1]) g = 1;
        end
        #1;
        chk("ready0", {31'd0, r0}, {31'd0, g == 0});
        chk("ready1", {31'd0, r1}, {31'd0, g == 1});
        chk("alu_a", alu_a, g >= 0 ? a[g] : 32'd0);
        chk("alu_op", {27'd0, alu_op}, g >= 0 ? {27'd0, op[g]} : 32'd0);
        @(posedge clk);
        if (rs) begin
            m_busy = 0; m_last = 1;
            for (int i = 0; i < 2; i++) begin m_rv[i] = 0; m_rr[i] = 0; m_rf[i] = 0; end
        end else if (g >= 0) begin
            res = alu(a[g], b[g], op[g]);
            m_rv[g] = 1; m_rr[g] = res[31:0]; m_rf[g] = res[32];
            m_last = g; m_busy = 1;
        end else if (m_busy && rd[m_last]) begin
            m_rv[m_last] = 0; m_busy = 0;
        end
        last_g = g;
        #1;
        chk("rsp0_valid", {31'd0, rv0}, {31'd0, m_rv[0]});
        chk("rsp1_valid", {31'd0, rv1}, {31'd0, m_rv[1]});
        chk("rsp0_result", rr0, m_rr[0]);
        chk("rsp1_result", rr1, m_rr[1]);
        chk("rsp0_flag", {31'd0, rf0}, {31'd0, m_rf[0]});
        chk("rsp1_flag", {31'd0, rf1}, {31'd0, m_rf[1]});
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin a[i] = 0; b[i] = 0; op[i] = 0; m_rv[i] = 0; m_rr[i] = 0; m_rf[i] = 0; end
        @(negedge clk);
        step(2'b11, 2'b00, 1);
        step(2'b11, 2'b00, 1);
        // single ADD
        a[0] = 5; b[0] = 3; op[0] = ALU_ADD;
        step(2'b01, 2'b00, 0);
        chk("add_valid", {31'd0, rv0}, 32'd1);
        chk("add_result", rr0, 32'd8);
        step(2'b00, 2'b01, 0);
        // contention from a fresh reset
        step(2'b00, 2'b00, 1);
        a[0] = 10; b[0] = 4; op[0] = ALU_SUB;
        a[1] = 32'hF0; b[1] = 32'h0F; op[1] = ALU_XOR;
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, 0);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            chk("grant_seq", last_g, 0);
`else
            chk("grant_seq", last_g, i % 2);
`endif
            if (last_g == 0) chk("sub_result", rr0, 32'd6);
            else chk("xor_result", rr1, 32'hFF);
            step(2'b11, 2'b11, 0);
        end
        // backpressure on port 1
        a[1] = 32'hFFFF_FFFF; b[1] = 1; op[1] = ALU_LTS;
        step(2'b10, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            step(2'b11, 2'b01, 0);
            chk("lts_flag", {31'd0, rf1}, 32'd1);
            chk("lts_valid", {31'd0, rv1}, 32'd1);
        end
        step(2'b00, 2'b10, 0);
        step(2'b00, 2'b00, 0);
        // reset while a response is pending
        step(2'b01, 2'b00, 0);
        step(2'b11, 2'b00, 1);
        chk("rst_valid0", {31'd0, rv0}, 32'd0);
        step(2'b11, 2'b00, 0);
        chk("post_rst_grant", last_g, 0);
        step(2'b00, 2'b11, 0);
        // port 1 offers only while busy, then withdraws
        step(2'b01, 2'b00, 0);
        step(2'b10, 2'b00, 0);
        step(2'b00, 2'b00, 0);
        step(2'b00, 2'b01, 0);
        step(2'b00, 2'b00, 0);
        chk("withdraw_valid1", {31'd0, rv1}, 32'd0);
        // random traffic including unknown opcodes and sporadic resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                a[i] = $urandom; b[i] = $urandom_range(0, 3) == 0 ? a[i] : $urandom;
                case ($urandom_range(0, 4))
                    0: op[i] = ALU_ADD;
                    1: op[i] = ALU_SUB;
                    2: op[i] = ALU_XOR;
                    3: op[i] = ALU_LTS;
                    default: op[i] = 5'd31;
                endcase
            end
            step(2'($urandom), 2'($urandom), $urandom_range(0, 39) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter OP_W, default 5, meaning width of the ALU opcode field, matching the alu_opcodes_pkg encoding.
REQ-002 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports reqN_valid_i (input, 1), reqN_a_i (input, 32), reqN_b_i (input, 32) and reqN_op_i (input, OP_W) for N = 0, 1: requester operation offer.
REQ-005 SHALL have port reqN_ready_o, output, 1, for N = 0, 1; request accepted when valid and ready are both high.
REQ-006 SHALL have ports rspN_valid_o (output, 1), rspN_result_o (output, 32) and rspN_flag_o (output, 1) for N = 0, 1: registered response.
REQ-007 SHALL have port rspN_ready_i, input, 1, for N = 0, 1: requester consumes the response.
REQ-008 SHALL have ports alu_a_o (output, 32), alu_b_o (output, 32) and alu_op_o (output, OP_W) driving the shared combinational ALU.
REQ-009 SHALL have ports alu_result_i (input, 32) and alu_flag_i (input, 1), returned from the shared ALU in the same cycle.

Function
REQ-010 SHALL implement a 2-state FSM: IDLE and RESP.
REQ-011 In IDLE, SHALL assert reqN_ready_o only for the granted requester; at most one ready is high per cycle.
REQ-012 Grant in IDLE SHALL be round-robin: with both valid, grant the port not granted last; with one valid, grant that port.
REQ-013 SHALL drive alu_a_o, alu_b_o and alu_op_o from the granted request's fields combinationally; with no grant, drive all zeros.
REQ-014 On an accept, SHALL register alu_result_i and alu_flag_i into the granted port's response registers, update the last-grant pointer, and move to RESP.
REQ-015 Latency SHALL be exactly one cycle: accept at edge N gives rspN_valid_o high from cycle N+1.
REQ-016 In RESP, SHALL hold rspN_valid_o, rspN_result_o and rspN_flag_o stable until rspN_ready_i is high, then return to IDLE.
REQ-017 In RESP, all reqN_ready_o SHALL be low; maximum throughput is one operation per 2 cycles.
REQ-018 The non-granted rspN_valid_o SHALL remain low throughout; rspN_result_o and rspN_flag_o of an idle port hold their last value.
REQ-019 A request whose valid drops before being accepted SHALL be discarded, with no state change.
REQ-020 Unknown opcodes SHALL pass through unchanged; the response carries whatever the ALU returns (result 0, flag 0).

Reset
REQ-021 On rst_i high at a clock edge, SHALL enter IDLE, clear both rspN_valid_o, rspN_result_o and rspN_flag_o to 0, and set the last-grant pointer to port 1, so port 0 wins first.
REQ-022 Reset during RESP SHALL drop the pending response without it being delivered.
REQ-023 While rst_i is high, all reqN_ready_o SHALL be low.

Configuration
REQ-024 Macro ALU_ARBITER_FIXED_PRIO_EN selects the grant policy.
REQ-025 When ALU_ARBITER_FIXED_PRIO_EN is defined, port 0 SHALL always win over port 1, and the last-grant pointer is unused.
REQ-026 When ALU_ARBITER_FIXED_PRIO_EN is undefined, the round-robin policy of REQ-012 SHALL apply.

Verification
REQ-027 Single request: req0 sends a=5, b=3, op=ALU_ADD. Required: accepted in that cycle; next cycle rsp0_valid_o=1, rsp0_result_o=8.
REQ-028 Contention: both valid every cycle, req0 op=ALU_SUB (10,4), req1 op=ALU_XOR (0xF0,0x0F). Required: grants alternate 0,1,0,1; results 6 and 0xFF.
REQ-029 Backpressure: hold rsp1_ready_i low for 5 cycles after a req1 ALU_LTS (-1,1). Required: rsp1_flag_o stays 1, rsp1_valid_o stays high, all reqN_ready_o low; on release, return to IDLE.
REQ-030 Mid-operation reset: assert rst_i in RESP. Required: next cycle rspN_valid_o=0, FSM in IDLE, port 0 granted first afterwards.
REQ-031 Fixed priority build (ALU_ARBITER_FIXED_PRIO_EN defined), both valid continuously. Required: port 0 granted every time; port 1 never granted.
REQ-032 Withdraw: req1 valid for one cycle while the FSM is in RESP, then deasserted. Required: no grant, no response on port 1.
